// File: rtl/seven_seg_pkg.sv
// Shared types, segment patterns and helpers for the multiplexed seven-segment driver.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_LOAD  = 2'd2
    } conv_state_t;

    // Segment order {a,b,c,d,e,f,g}, logical polarity (1 = segment on).
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Non-decimal nibbles cannot come out of the converter; show them blank anyway.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    // 10^n, used at elaboration time to derive the over-range limit (n <= 8 fits 32 bits).
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   CONV_IDLE  | ready for a new value; accept latches it and arms the counter
//   CONV_SHIFT | one adjust+shift per cycle until the down-counter reaches zero
//   CONV_LOAD  | done pulse: bcd/over are final and copied by the consumer
module bcd_dabble_seq
    import seven_seg_pkg::*;
#(
    parameter int BIN_WIDTH  = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_WIDTH-1:0]    bin,
    input  logic                    start,
    output logic                    ready,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    over,
    output logic                    done
);

    localparam int          BCD_W  = 4 * NUM_DIGITS;
    localparam int          ITER_W = $clog2(BIN_WIDTH + 1);
    localparam logic [31:0] LIMIT  = pow10(NUM_DIGITS) - 32'd1;

    conv_state_t        state;
    conv_state_t        state_next;
    logic               accept;
    logic [BIN_WIDTH-1:0] bin_work;
    logic [BCD_W-1:0]   bcd_work;
    logic [BCD_W-1:0]   bcd_adj;
    logic [ITER_W-1:0]  iter_cnt;
    logic               over_work;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake/done outputs; ready is held low while reset is asserted.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            CONV_IDLE: begin
                ready  = !rst;
                accept = start && !rst;
                if (accept) begin
                    state_next = CONV_SHIFT;
                end
            end
            CONV_SHIFT: begin
                if (iter_cnt == '0) begin
                    state_next = CONV_LOAD;
                end
            end
            CONV_LOAD: begin
                done       = 1'b1;
                state_next = CONV_IDLE;
            end
            default: state_next = CONV_IDLE;
        endcase
    end

    // Add 3 to every nibble >= 5 ahead of the shift.
    always_comb begin
        bcd_adj = bcd_work;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_work[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_work[4*d +: 4] + 4'd3;
            end
        end
    end

    // Working registers: latch on accept, then shift {bcd, bin} left once per iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_work  <= '0;
            bcd_work  <= '0;
            iter_cnt  <= '0;
            over_work <= 1'b0;
        end else if (accept) begin
            bin_work  <= bin;
            bcd_work  <= '0;
            iter_cnt  <= ITER_W'(BIN_WIDTH);
            over_work <= ({{(32-BIN_WIDTH){1'b0}}, bin} > LIMIT);
        end else if (state == CONV_SHIFT && iter_cnt != '0) begin
            bcd_work <= {bcd_adj[BCD_W-2:0], bin_work[BIN_WIDTH-1]};
            bin_work <= bin_work << 1;
            iter_cnt <= iter_cnt - ITER_W'(1);
        end
    end

    assign bcd  = bcd_work;
    assign over = over_work;

endmodule

// File: rtl/seven_seg_mux_nd.sv
// N-digit multiplexed seven-segment driver: display buffer, digit scan, PWM dimming,
// leading-zero blanking and polarity-mapped output registers.
module seven_seg_mux_nd
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int BIN_WIDTH     = 14,
    parameter int SCAN_DIV      = 16384,
    parameter int COMMON_ANODE  = 0,
    parameter int BLANK_LEADING = 1,
    parameter int BRIGHT_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIN_WIDTH-1:0]    value,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [BRIGHT_WIDTH-1:0] brightness,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic                    overflow
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Physical = logical ^ mask. Common cathode drives digit lines low and segments high.
    localparam logic [NUM_DIGITS-1:0] EN_MASK  = (COMMON_ANODE != 0) ? '0 : '1;
    localparam logic [6:0]            SEG_MASK = (COMMON_ANODE != 0) ? 7'h7f : 7'h00;
    localparam logic                  DP_MASK  = (COMMON_ANODE != 0);

    logic [BCD_W-1:0]        conv_bcd;
    logic                    conv_over;
    logic                    conv_done;
    logic [BCD_W-1:0]        disp_buf;
    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        dig_idx;
    logic [BRIGHT_WIDTH-1:0] pwm;
    logic                    lit;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lead_blank;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   en_log;
    logic [6:0]              seg_log;
    logic                    dp_log;

    bcd_dabble_seq #(
        .BIN_WIDTH  (BIN_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .bin   (value),
        .start (value_valid),
        .ready (value_ready),
        .bcd   (conv_bcd),
        .over  (conv_over),
        .done  (conv_done)
    );

    // Display buffer and over-range flag update together when the converter finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_buf <= '0;
            overflow <= 1'b0;
        end else if (conv_done) begin
            disp_buf <= conv_bcd;
            overflow <= conv_over;
        end
    end

    // Free-running slot counter; each wrap advances to the next digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            if (dig_idx == IDX_W'(NUM_DIGITS - 1)) begin
                dig_idx <= '0;
            end else begin
                dig_idx <= dig_idx + IDX_W'(1);
            end
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        zero_run   = 1'b1;
        lead_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run      = zero_run && (disp_buf[4*i +: 4] == 4'd0);
            lead_blank[i] = zero_run && (i > 0) && (BLANK_LEADING != 0);
        end
    end

    assign pwm = scan_cnt[BRIGHT_WIDTH-1:0];
    assign lit = (pwm < brightness);

    // Logical pin values for the current slot; everything is dark outside the PWM on-time.
    always_comb begin
        nibble  = disp_buf[4*int'(dig_idx) +: 4];
        en_log  = '0;
        seg_log = SEG_BLANK;
        dp_log  = 1'b0;
        if (lit) begin
            en_log[dig_idx] = 1'b1;
            dp_log          = dp[dig_idx];
            if (overflow) begin
                seg_log = SEG_DASH;
            end else if (lead_blank[dig_idx]) begin
                seg_log = SEG_BLANK;
            end else begin
                seg_log = seg_decode(nibble);
            end
        end
    end

    // Output register: enables and data change on the same edge, polarity applied here only.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_en <= EN_MASK;
            segments <= SEG_MASK;
            dp_out   <= DP_MASK;
        end else begin
            digit_en <= en_log ^ EN_MASK;
            segments <= seg_log ^ SEG_MASK;
            dp_out   <= dp_log ^ DP_MASK;
        end
    end

endmodule
